if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the pipelined CPU: owns the program counter, drives the
//  instruction memory address, and registers fetched instruction + PC into the IF/ID
//  pipeline register consumed by decode/imm_gen. Supports hazard stalls, branch/jump
//  redirect with flush, and a halt opcode that freezes fetch until reset.
// PARAMETERS
//  IMEM_AW   8        instruction memory address width (word addressed, 256 deep)
//  RESET_PC  32'd0    PC value loaded on reset
//  HALT_OP   4'b1110  opcode (inst[31:28]) that stops fetch
//  NOP       32'd0    instruction word injected as a bubble
// PORTS
//  clk           in   1         single clock, all state updates on posedge
//  rst           in   1         synchronous, active-high reset
//  stall         in   1         hazard unit: hold PC and IF/ID contents
//  redirect      in   1         EX stage: branch/jump taken this cycle
//  redirect_pc   in   32        target PC when redirect=1
//  imem_addr     out  IMEM_AW   to inst_mem addr; combinational = pc[IMEM_AW-1:0]
//  imem_inst     in   32        from inst_mem (combinational read of imem_addr)
//  if_id_inst    out  32        registered instruction to decode
//  if_id_pc      out  32        registered PC of if_id_inst
//  if_id_valid   out  1         1 = if_id_inst is a real instruction, 0 = bubble
//  halted        out  1         1 once HALT_OP has been fetched
//  fetch_count   out  32        number of instructions accepted into IF/ID
// BEHAVIOUR
//  - Reset (rst=1 at posedge): pc<=RESET_PC, if_id_inst<=NOP, if_id_pc<=0, if_id_valid<=0,
//    halted<=0, fetch_count<=0, state<=FETCH. Reset overrides every other input.
//  - PC increments by 1 (word addressing); 32-bit add wraps 0xFFFFFFFF->0. imem_addr takes
//    low IMEM_AW bits, so fetch wraps 255->0 with no special handling.
//  - Latency: instruction at pc appears on if_id_inst one cycle after pc presented.
//  - FSM states: FETCH, HALT. Priority per posedge in FETCH: rst > redirect > stall > advance.
//    * redirect=1: pc<=redirect_pc; if_id_inst<=NOP, if_id_valid<=0 (flush wrong-path
//      instruction); fetch_count unchanged. Redirect wins over simultaneous stall.
//    * stall=1 (no redirect): pc, if_id_*, fetch_count all hold.
//    * advance: if_id_inst<=imem_inst, if_id_pc<=pc, if_id_valid<=1, fetch_count+=1;
//      if imem_inst[31:28]==HALT_OP -> halted<=1, state<=HALT, pc holds; else pc<=pc+1.
//  - HALT: pc and fetch_count frozen; if_id_inst<=NOP, if_id_valid<=0 from the next edge
//    (halt instruction itself passes through once). stall ignored; redirect=1 in HALT
//    leaves HALT: pc<=redirect_pc, halted<=0, state<=FETCH (allows flush of a speculative
//    halt behind a taken branch). Only rst or redirect exits HALT.
//  - fetch_count wraps at 2^32 silently.
//  - No X may reach outputs after first reset edge; before reset outputs are don't-care.
// STRUCTURE
//  - Shared package cpu_pkg: NOP word, opcode field slice [31:28], HALT opcode, fetch
//    FSM state enum {FETCH, HALT}; imm_gen and decode use the same opcode constants.
//  - One sub-module: if_id_reg (stall/flush-capable pipeline register for inst, pc,
//    valid); PC, FSM and counter stay in if_stage.
// TESTING
//  - Reset then 4 free-running cycles, imem = {A,B,C,D} at 0..3 -> if_id_inst A,B,C,D,
//    if_id_pc 0..3, valid=1 each, fetch_count=4.
//  - stall=1 for 2 cycles while if_id holds B at pc=1 -> if_id_inst=B, imem_addr=2,
//    fetch_count unchanged for both cycles; resumes with C.
//  - redirect=1 & stall=1 same edge, redirect_pc=0x40 -> imem_addr=0x40, if_id_valid=0,
//    if_id_inst=NOP; next edge if_id_pc=0x40, valid=1.
//  - pc=255 free-running -> imem_addr 255 then 0, if_id_pc=256 for second fetch.
//  - HALT_OP word at addr 5 -> if_id_inst=halt word once, halted=1, then NOP/valid=0
//    forever, pc stays 5; later redirect to 0x10 -> halted=0, fetch resumes at 0x10.
//  - rst asserted mid-stall with valid data in IF/ID -> next edge pc=RESET_PC,
//    if_id_valid=0, fetch_count=0, halted=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Constants and types shared by the fetch, decode and imm_gen stages.
// The opcode field, the bubble word and the fetch FSM encoding are defined here only.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 28;
  localparam int unsigned OPC_W  = OPC_HI - OPC_LO + 1;

  localparam logic [XLEN-1:0]  NOP_WORD = 32'd0;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'b1110;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [XLEN-1:0] inst);
    return inst[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: carries instruction, its PC and a valid bit to decode.
// Flush turns the slot into a bubble and beats hold; hold freezes all three fields.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            hold,
  input  logic [XLEN-1:0] d_inst,
  input  logic [XLEN-1:0] d_pc,
  output logic [XLEN-1:0] q_inst,
  output logic [XLEN-1:0] q_pc,
  output logic            q_valid
);

  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      // The PC of a bubble is meaningless, so it is left untouched.
      inst_d  = NOP;
      valid_d = 1'b0;
    end else if (!hold) begin
      inst_d  = d_inst;
      pc_d    = d_pc;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= NOP;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign q_inst  = inst_q;
  assign q_pc    = pc_q;
  assign q_valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, fetch FSM (FETCH/HALT), accepted-instruction
// counter, and the IF/ID register feeding decode.
module if_stage
  import cpu_pkg::*;
#(
  parameter int unsigned      IMEM_AW  = 8,
  parameter logic [XLEN-1:0]  RESET_PC = 32'd0,
  parameter logic [OPC_W-1:0] HALT_OP  = OPC_HALT,
  parameter logic [XLEN-1:0]  NOP      = NOP_WORD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_inst,
  output logic [XLEN-1:0]    if_id_inst,
  output logic [XLEN-1:0]    if_id_pc,
  output logic               if_id_valid,
  output logic               halted,
  output logic [XLEN-1:0]    fetch_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;
  logic            ifid_flush;
  logic            ifid_hold;
  logic            is_halt_op;

  assign is_halt_op = (opcode_of(imem_inst) == HALT_OP);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;
    ifid_flush    = 1'b0;
    ifid_hold     = 1'b0;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          // Taken branch/jump: drop the wrong-path word, even if a stall is also raised.
          pc_d       = redirect_pc;
          ifid_flush = 1'b1;
        end else if (stall) begin
          ifid_hold = 1'b1;
        end else begin
          fetch_count_d = fetch_count_q + 32'd1;
          if (is_halt_op) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            pc_d = pc_q + 32'd1;
          end
        end
      end
      HALT: begin
        // Halt word already went through once; feed bubbles until a redirect revives fetch.
        ifid_flush = 1'b1;
        if (redirect) begin
          pc_d     = redirect_pc;
          halted_d = 1'b0;
          state_d  = FETCH;
        end
      end
      default: begin
        ifid_flush = 1'b1;
        state_d    = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg #(
    .NOP (NOP)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .flush   (ifid_flush),
    .hold    (ifid_hold),
    .d_inst  (imem_inst),
    .d_pc    (pc_q),
    .q_inst  (if_id_inst),
    .q_pc    (if_id_pc),
    .q_valid (if_id_valid)
  );

  assign imem_addr   = pc_q[IMEM_AW-1:0];
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a behavioural instruction memory plus hand-computed checks.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [7:0]  imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] imem [256];
  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] W_A    = 32'h1111_00A0;
  localparam logic [31:0] W_B    = 32'h2222_00B0;
  localparam logic [31:0] W_C    = 32'h3333_00C0;
  localparam logic [31:0] W_D    = 32'h4444_00D0;
  localparam logic [31:0] W_HALT = 32'hE000_0055;

  always #5 clk = ~clk;

  assign imem_inst = imem[imem_addr];

  if_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_inst   (imem_inst),
    .if_id_inst  (if_id_inst),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_addr, input logic [31:0] e_inst,
                           input logic [31:0] e_pc, input logic e_valid, input logic e_halt,
                           input logic [31:0] e_cnt);
    check({tag, ".addr"},  {24'd0, imem_addr}, e_addr);
    check({tag, ".inst"},  if_id_inst, e_inst);
    check({tag, ".pc"},    if_id_pc, e_pc);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
    check({tag, ".halt"},  {31'd0, halted}, {31'd0, e_halt});
    check({tag, ".cnt"},   fetch_count, e_cnt);
    $display("step %-10s addr=%h inst=%h pc=%h valid=%b halted=%b cnt=%0d",
             tag, imem_addr, if_id_inst, if_id_pc, if_id_valid, halted, fetch_count);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'h1000_0000 | i;
    imem[0] = W_A;
    imem[1] = W_B;
    imem[2] = W_C;
    imem[3] = W_D;
    imem[5] = W_HALT;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    step(); step();
    check_all("reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);

    // Free-running fetch of A..D
    rst = 1'b0;
    step(); check_all("fetchA", 32'd1, W_A, 32'd0, 1'b1, 1'b0, 32'd1);
    step(); check_all("fetchB", 32'd2, W_B, 32'd1, 1'b1, 1'b0, 32'd2);
    step(); check_all("fetchC", 32'd3, W_C, 32'd2, 1'b1, 1'b0, 32'd3);
    step(); check_all("fetchD", 32'd4, W_D, 32'd3, 1'b1, 1'b0, 32'd4);

    // Restart, then stall with B in IF/ID
    rst = 1'b1;
    step(); check_all("rst2", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    step(); check_all("reA", 32'd1, W_A, 32'd0, 1'b1, 1'b0, 32'd1);
    step(); check_all("reB", 32'd2, W_B, 32'd1, 1'b1, 1'b0, 32'd2);
    stall = 1'b1;
    step(); check_all("stall1", 32'd2, W_B, 32'd1, 1'b1, 1'b0, 32'd2);
    step(); check_all("stall2", 32'd2, W_B, 32'd1, 1'b1, 1'b0, 32'd2);
    stall = 1'b0;
    step(); check_all("resumeC", 32'd3, W_C, 32'd2, 1'b1, 1'b0, 32'd3);

    // Redirect wins over stall on the same edge
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h40;
    step(); check_all("redir", 32'h40, 32'd0, 32'd2, 1'b0, 1'b0, 32'd3);
    redirect = 1'b0; stall = 1'b0;
    step(); check_all("at40", 32'h41, 32'h1000_0040, 32'h40, 1'b1, 1'b0, 32'd4);

    // Address wrap 255 -> 0 while PC keeps counting
    redirect = 1'b1; redirect_pc = 32'hFF;
    step(); check_all("toFF", 32'hFF, 32'd0, 32'h40, 1'b0, 1'b0, 32'd4);
    redirect = 1'b0;
    step(); check_all("fetchFF", 32'h00, 32'h1000_00FF, 32'hFF, 1'b1, 1'b0, 32'd5);
    step(); check_all("fetch100", 32'h01, W_A, 32'h100, 1'b1, 1'b0, 32'd6);

    // Halt opcode at address 5
    redirect = 1'b1; redirect_pc = 32'd4;
    step(); check_all("to4", 32'd4, 32'd0, 32'h100, 1'b0, 1'b0, 32'd6);
    redirect = 1'b0;
    step(); check_all("fetch4", 32'd5, 32'h1000_0004, 32'd4, 1'b1, 1'b0, 32'd7);
    step(); check_all("fetchHalt", 32'd5, W_HALT, 32'd5, 1'b1, 1'b1, 32'd8);
    step(); check_all("halt1", 32'd5, 32'd0, 32'd5, 1'b0, 1'b1, 32'd8);
    stall = 1'b1;
    step(); check_all("haltStall", 32'd5, 32'd0, 32'd5, 1'b0, 1'b1, 32'd8);
    stall = 1'b0;
    step(); check_all("halt3", 32'd5, 32'd0, 32'd5, 1'b0, 1'b1, 32'd8);
    redirect = 1'b1; redirect_pc = 32'h10;
    step(); check_all("unhalt", 32'h10, 32'd0, 32'd5, 1'b0, 1'b0, 32'd8);
    redirect = 1'b0;
    step(); check_all("fetch10", 32'h11, 32'h1000_0010, 32'h10, 1'b1, 1'b0, 32'd9);

    // 32-bit PC wrap 0xFFFFFFFF -> 0
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step(); check_all("toMax", 32'hFF, 32'd0, 32'h10, 1'b0, 1'b0, 32'd9);
    redirect = 1'b0;
    step(); check_all("fetchMax", 32'h00, 32'h1000_00FF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd10);
    step(); check_all("fetch0", 32'h01, W_A, 32'h0, 1'b1, 1'b0, 32'd11);

    // Reset during a stall with valid data held
    stall = 1'b1;
    step(); check_all("preRst", 32'h01, W_A, 32'h0, 1'b1, 1'b0, 32'd11);
    rst = 1'b1;
    step(); check_all("rstStall", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0; stall = 1'b0;
    step(); check_all("postRst", 32'd1, W_A, 32'd0, 1'b1, 1'b0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
